// File: rtl/counter_cascade.sv
// counter_cascade
// ---------------------------------------------------------------------------
// Multi-digit modulo counter: DIGITS cascaded digits, each NBITS wide, each
// counting 0..MAXIMUM_VALUE. The counter counts up or down and has a
// synchronous clear, a clamped parallel load, and either wraps or stops at
// the terminal count. It provides per-digit and global terminal-count flags.
//
// Optional feature (macro COUNTER_CASCADE_SNAPSHOT_EN): adds a snapshot
// register that captures the pre-edge count when snapshot_i is high.
//
// Ports
//   clk_i             system clock, rising edge
//   rst_ni            asynchronous active-low reset
//   snapshot_i        (macro only) capture the current count
//   snapshot_value_o  (macro only) last captured count
//   enable_i          count enable for the least-significant digit
//   up_down_i         1 = count up, 0 = count down
//   clear_i           synchronous clear; highest priority
//   load_i            synchronous parallel load
//   load_value_i      load data; digit 0 in the LSBs
//   counter_o         current count; digit 0 in the LSBs
//   digit_carry_o     per-digit terminal flag (combinational)
//   carry_o           AND of all digit_carry_o bits (combinational)
//   overflow_o        registered one-cycle pulse after a wrap
// ---------------------------------------------------------------------------
module counter_cascade #(
    parameter int unsigned NBITS         = 4,
    parameter int unsigned MAXIMUM_VALUE = 9,
    parameter int unsigned DIGITS        = 2,
    parameter bit          STOP_AT_END   = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
`ifdef COUNTER_CASCADE_SNAPSHOT_EN
    input  logic                    snapshot_i,
    output logic [DIGITS*NBITS-1:0] snapshot_value_o,
`endif
    input  logic                    enable_i,
    input  logic                    up_down_i,
    input  logic                    clear_i,
    input  logic                    load_i,
    input  logic [DIGITS*NBITS-1:0] load_value_i,
    output logic [DIGITS*NBITS-1:0] counter_o,
    output logic [DIGITS-1:0]       digit_carry_o,
    output logic                    carry_o,
    output logic                    overflow_o
);

    localparam logic [NBITS-1:0] MaxVal = NBITS'(MAXIMUM_VALUE);

    logic [DIGITS-1:0][NBITS-1:0] cnt_q, cnt_d;
    logic                         ovf_q, ovf_d;
    logic [NBITS-1:0]             ld_slice;
    logic                         step;

    // Terminal flags depend only on the current count and direction so that
    // an external cascade sees a direction change in the same cycle.
    always_comb begin
        digit_carry_o = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            digit_carry_o[i] = up_down_i ? (cnt_q[i] == MaxVal) : (cnt_q[i] == '0);
        end
    end

    assign carry_o = &digit_carry_o;

    always_comb begin
        cnt_d    = cnt_q;
        ovf_d    = 1'b0;
        ld_slice = '0;
        step     = 1'b1;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                ld_slice = load_value_i[i*NBITS +: NBITS];
                cnt_d[i] = (ld_slice > MaxVal) ? MaxVal : ld_slice;
            end
        end else if (enable_i && !(carry_o && STOP_AT_END)) begin
            // Ripple enable within a single edge: digit i steps only when
            // every lower digit is at its terminal value.
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (step) begin
                    if (up_down_i) begin
                        cnt_d[i] = (cnt_q[i] == MaxVal) ? '0 : cnt_q[i] + NBITS'(1);
                    end else begin
                        cnt_d[i] = (cnt_q[i] == '0) ? MaxVal : cnt_q[i] - NBITS'(1);
                    end
                end
                step = step & digit_carry_o[i];
            end
            // Every digit was terminal, so this edge is a full wrap.
            ovf_d = carry_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign counter_o  = cnt_q;
    assign overflow_o = ovf_q;

`ifdef COUNTER_CASCADE_SNAPSHOT_EN
    logic [DIGITS*NBITS-1:0] snap_q;

    // Captures the pre-edge count, so a coincident clear does not affect it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            snap_q <= '0;
        end else if (snapshot_i) begin
            snap_q <= cnt_q;
        end
    end

    assign snapshot_value_o = snap_q;
`endif

endmodule

// File: tb/tb_counter_cascade.sv
// Self-checking bench for counter_cascade (DIGITS=2, NBITS=4, MAXIMUM_VALUE=9).
// Two instances share stimulus: one wrapping, one stopping at the end.
// The reference model treats the count as a decimal integer 0..99.
module tb_counter_cascade;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable, up_down, clear, load;
    logic [7:0] load_value;
    logic [7:0] cnt_w, cnt_s;
    logic [1:0] dc_w, dc_s;
    logic       cy_w, cy_s, ovf_w, ovf_s;
`ifdef COUNTER_CASCADE_SNAPSHOT_EN
    logic       snapshot;
    logic [7:0] snap_w, snap_s;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    counter_cascade #(
        .NBITS(4), .MAXIMUM_VALUE(9), .DIGITS(2), .STOP_AT_END(1'b0)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
`ifdef COUNTER_CASCADE_SNAPSHOT_EN
        .snapshot_i(snapshot), .snapshot_value_o(snap_w),
`endif
        .enable_i(enable), .up_down_i(up_down), .clear_i(clear), .load_i(load),
        .load_value_i(load_value), .counter_o(cnt_w), .digit_carry_o(dc_w),
        .carry_o(cy_w), .overflow_o(ovf_w)
    );

    counter_cascade #(
        .NBITS(4), .MAXIMUM_VALUE(9), .DIGITS(2), .STOP_AT_END(1'b1)
    ) dut_stop (
        .clk_i(clk), .rst_ni(rst_n),
`ifdef COUNTER_CASCADE_SNAPSHOT_EN
        .snapshot_i(snapshot), .snapshot_value_o(snap_s),
`endif
        .enable_i(enable), .up_down_i(up_down), .clear_i(clear), .load_i(load),
        .load_value_i(load_value), .counter_o(cnt_s), .digit_carry_o(dc_s),
        .carry_o(cy_s), .overflow_o(ovf_s)
    );

    typedef struct {
        logic [7:0] cnt;
        logic       ovf;
        logic [1:0] dc;
        logic       cy;
        logic [7:0] cnt_s;
        logic       ovf_s;
    } exp_t;

    exp_t sb[$];
    int   n  = 0;  // wrapping model count, 0..99
    int   ns = 0;  // stopping model count, 0..99

    function automatic logic [7:0] bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [1:0] dcf(input int v, input logic up);
        logic [1:0] r;
        if (up) r = {(v / 10) == 9, (v % 10) == 9};
        else    r = {(v / 10) == 0, (v % 10) == 0};
        return r;
    endfunction

    function automatic int clamp9(input int d);
        return (d > 9) ? 9 : d;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the models with the currently driven inputs, push the expected
    // outcome, take one clock edge, then pop and compare.
    task automatic apply(input string tag);
        exp_t e;
        int   ov;
        ov = 0;
        if (clear) begin
            n = 0; ns = 0;
        end else if (load) begin
            n  = clamp9(int'(load_value[7:4])) * 10 + clamp9(int'(load_value[3:0]));
            ns = n;
        end else if (enable) begin
            if (up_down) begin
                if (n == 99) begin n = 0; ov = 1; end else n++;
                if (ns < 99) ns++;
            end else begin
                if (n == 0) begin n = 99; ov = 1; end else n--;
                if (ns > 0) ns--;
            end
        end
        e.cnt   = bcd(n);
        e.ovf   = (ov != 0);
        e.dc    = dcf(n, up_down);
        e.cy    = &dcf(n, up_down);
        e.cnt_s = bcd(ns);
        e.ovf_s = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".cnt"},   cnt_w,        e.cnt);
        check({tag, ".ovf"},   {7'd0, ovf_w}, {7'd0, e.ovf});
        check({tag, ".dc"},    {6'd0, dc_w},  {6'd0, e.dc});
        check({tag, ".cy"},    {7'd0, cy_w},  {7'd0, e.cy});
        check({tag, ".cnt_s"}, cnt_s,        e.cnt_s);
        check({tag, ".ovf_s"}, {7'd0, ovf_s}, {7'd0, e.ovf_s});
    endtask

    initial begin
        int ovf_pulses;
        rst_n = 1'b0; enable = 1'b0; up_down = 1'b1; clear = 1'b0; load = 1'b0;
        load_value = 8'h00;
`ifdef COUNTER_CASCADE_SNAPSHOT_EN
        snapshot = 1'b0;
`endif
        #2;
        check("reset.cnt", cnt_w, 8'h00);
        check("reset.ovf", {7'd0, ovf_w}, 8'h00);
        check("reset.dc_up", {6'd0, dc_w}, 8'h00);
        check("reset.cy_up", {7'd0, cy_w}, 8'h00);
        up_down = 1'b0;
        #1;
        check("reset.dc_down", {6'd0, dc_w}, 8'h03);
        check("reset.cy_down", {7'd0, cy_w}, 8'h01);
        up_down = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Full up count through the wrap.
        enable = 1'b1;
        ovf_pulses = 0;
        for (int i = 0; i < 100; i++) begin
            apply("up100");
            if (ovf_w) ovf_pulses++;
        end
        check("up100.pulses", 8'(ovf_pulses), 8'd1);
        enable = 1'b0;
        apply("hold");

        // Load 0x10 and count down across the digit boundary.
        load = 1'b1; load_value = 8'h10;
        apply("load10");
        load = 1'b0; up_down = 1'b0;
        #1;
        check("load10.dc_down", {6'd0, dc_w}, 8'h01);
        enable = 1'b1;
        apply("down1");
        apply("down2");
        enable = 1'b0;

        // Upper digit clamped on load.
        load = 1'b1; load_value = 8'hF3;
        apply("clamp");
        load_value = 8'h45;
        apply("load45");

        // Clear beats load and enable.
        clear = 1'b1; load_value = 8'h77; enable = 1'b1;
        apply("clear_prio");
        clear = 1'b0;

        // End of count: wrap instance wraps, stop instance holds at 0x99.
        load = 1'b1; load_value = 8'h98; enable = 1'b0; up_down = 1'b1;
        apply("load98");
        load = 1'b0; enable = 1'b1;
        apply("end1");
        apply("end2");
        apply("end3");

        // Down wrap from zero.
        enable = 1'b0; load = 1'b1; load_value = 8'h00;
        apply("load00");
        load = 1'b0; enable = 1'b1; up_down = 1'b0;
        apply("down_wrap");
        apply("down_after");

        // Asynchronous reset mid-cycle.
        enable = 1'b0; load = 1'b1; load_value = 8'h57;
        apply("load57");
        load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async.cnt", cnt_w, 8'h00);
        check("async.cnt_s", cnt_s, 8'h00);
        check("async.ovf", {7'd0, ovf_w}, 8'h00);
        n = 0; ns = 0;
        #2 rst_n = 1'b1;
        up_down = 1'b1; enable = 1'b1;
        apply("post_reset");

`ifdef COUNTER_CASCADE_SNAPSHOT_EN
        enable = 1'b0; load = 1'b1; load_value = 8'h23;
        apply("load23");
        load = 1'b0; enable = 1'b1; snapshot = 1'b1;
        apply("snap_take");
        snapshot = 1'b0;
        check("snap.value", snap_w, 8'h23);
        apply("snap_run1");
        apply("snap_run2");
        check("snap.hold", snap_w, 8'h23);
        load_value = 8'h61; load = 1'b1; enable = 1'b0;
        apply("load61");
        load = 1'b0; clear = 1'b1; snapshot = 1'b1;
        apply("snap_clear");
        clear = 1'b0; snapshot = 1'b0;
        check("snap.pre_clear", snap_w, 8'h61);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
